frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Frame-level scheduler for the tiny shader display path. It owns the horizontal and vertical pixel counters, and derives hsync, vsync and blank from them. It issues one shader-start pulse per active pixel. It also arbitrates the shader program memory between the pixel pipeline and the external program loader, granting the loader only during vertical blanking. It sits between the top level and the shader core.

## Interface
Parameters:
- H_RES, 640: active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porch and sync widths, in pixels
- V_RES, 480: active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porch and sync widths, in lines
- POLARITY, 0: 1 = sync active-high, 0 = sync active-low
- PIX_DIV, 4: clk cycles per pixel, i.e. the shader cycles available per pixel; must be ≥ 2

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- enable  in  1  advance timing when high; freeze when low
- load_req  in  1  loader requests program memory
- load_done  in  1  loader releases program memory (1-cycle pulse)
- load_grant  out  1  loader owns program memory
- frame_skip  out  1  current active frame is not shaded
- hsync, vsync, blank  out  1 each  display timing
- x  out  signed XW  horizontal counter; XW = $clog2(H_RES+H_FP+H_SYNC+H_BP)+1, 11 by default
- y  out  signed YW  vertical counter; YW defined the same way, 11 by default
- pix_stb  out  1  last clk cycle of each pixel
- shader_start  out  1  first clk cycle of each active pixel
- line_start, frame_start  out  1  end-of-line and end-of-frame pulses

## Operation
- Counter ranges: x runs -(H_FP+H_SYNC+H_BP) .. H_RES-1; y runs -(V_FP+V_SYNC+V_BP) .. V_RES-1. Negative values are blanking; 0 is the first active pixel or line.
- Divider: div counts 0..PIX_DIV-1 while enable is high. pix_stb = enable && div==PIX_DIV-1.
- x advance: x advances by 1 on pix_stb. At H_RES-1 it wraps to -(H_FP+H_SYNC+H_BP).
- line_start = pix_stb && x==H_RES-1. y advances on line_start and wraps the same way.
- frame_start = line_start && y==V_RES-1.
- hsync active when -(H_SYNC+H_BP) ≤ x < -H_BP; output level follows POLARITY. vsync uses the same rule on y.
- blank = (x<0) || (y<0).
- shader_start = enable && div==0 && !blank && !frame_skip.
- Arbiter states:
  - IDLE → GRANTED when load_req && -(V_FP+V_SYNC+V_BP) ≤ y ≤ -2. This guarantees at least one full blank line of ownership.
  - GRANTED → IDLE on load_done.
  - load_grant = (state==GRANTED).
  - The arbiter ignores enable.
- frame_skip:
  - Set at the blank-to-active boundary (line_start && y==-1) if the state is GRANTED and load_done is not present that cycle.
  - Cleared on frame_start.
  - If load_done coincides with the boundary, release wins and there is no skip.
- enable low: div, x and y hold; pix_stb, line_start, frame_start and shader_start are 0.

## Timing
- Reset values: div=0, x=-160, y=-45, state IDLE, load_grant=0, frame_skip=0, blank=1. With POLARITY=0, hsync=1 and vsync=1; all pulse outputs are 0.
- x, y, div, state and frame_skip are registered.
- hsync, vsync, blank and all pulses are combinational from the registers, so they have zero latency relative to x, y and div.
- load_grant rises 1 cycle after a qualifying load_req and falls 1 cycle after load_done.
- Frame length is exactly (H_RES+H_FP+H_SYNC+H_BP) × (V_RES+V_FP+V_SYNC+V_BP) × PIX_DIV enabled cycles: 1,680,000 with the defaults.
- Reset asserted mid-frame: all state returns to reset values on the next edge, including dropping load_grant.

## Structure
- Package frame_sched_pkg holds:
  - default 640x480 timing constants
  - typedef enum arb_state_t {IDLE, GRANTED}
  - a function computing counter width from the total
- Sub-module sync_counter: one signed axis counter with parameters RES/FP/SYNC/BP/POLARITY and ports step, wrap, sync, blank and count. It is instantiated twice, for horizontal and vertical, with the vertical step = line_start.

## Test plan
- Reset and defaults: after reset, run 1,680,000 enabled cycles → exactly one frame_start, 525 line_starts, 800×525 pix_stb, and x=-160, y=-45 again.
- Sync placement: observe line 0 → hsync low for x in -144..-49 (96 pixels); vsync low for y in -35..-34 only; blank=0 only for x,y ≥ 0.
- Shader pulses: one active frame → 307,200 shader_start pulses, each on div==0. No pulse when blank=1.
- Enable gating: drop enable for 37 cycles mid-line → x, y and div unchanged and no pulses. The frame length grows by exactly 37 cycles.
- Arbiter in time: load_req at y=-40 with load_done at y=-10 → grant for exactly that interval and frame_skip stays 0. load_req at y=-1 or y=100 → no grant until the next blank with y ≤ -2.
- Arbiter late: grant still held at the boundary → frame_skip=1 for the entire next active frame with zero shader_start. load_done on the exact boundary cycle → frame_skip stays 0.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared timing defaults, arbiter state type and counter-width helper for the
// frame scheduler and its axis counters.
package frame_sched_pkg;

  localparam int DEF_H_RES  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  typedef enum logic {
    IDLE,
    GRANTED
  } arb_state_t;

  // One extra bit over the total so the negative blanking range fits as signed.
  function automatic int cnt_width(input int total);
    return $clog2(total) + 1;
  endfunction

endpackage

// File: rtl/sync_counter.sv
// One signed display-timing axis: counts -(FP+SYNC+BP) .. RES-1 on step and
// derives the sync level, blanking and the end-of-axis wrap pulse.
module sync_counter
  import frame_sched_pkg::*;
#(
  parameter int RES      = DEF_H_RES,
  parameter int FP       = DEF_H_FP,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BP       = DEF_H_BP,
  parameter int POLARITY = 0,
  parameter int W        = cnt_width(RES + FP + SYNC + BP)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  output logic                wrap,
  output logic                sync,
  output logic                blank,
  output logic signed [W-1:0] count
);

  localparam logic signed [W-1:0] CNT_MIN = W'(-(FP + SYNC + BP));
  localparam logic signed [W-1:0] CNT_MAX = W'(RES - 1);
  localparam logic signed [W-1:0] SYNC_LO = W'(-(SYNC + BP));
  localparam logic signed [W-1:0] SYNC_HI = W'(-BP);

  logic signed [W-1:0] count_q, count_d;
  logic                sync_act;

  always_comb begin
    // NOTE: every combinational output takes a default first, so no path can
    // leave it unassigned and infer a latch.
    count_d = count_q;
    if (step) begin
      count_d = (count_q == CNT_MAX) ? CNT_MIN : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (reset) begin
      count_q <= CNT_MIN;
    end else begin
      count_q <= count_d;
    end
  end

  assign sync_act = (count_q >= SYNC_LO) && (count_q < SYNC_HI);
  assign sync     = (POLARITY != 0) ? sync_act : !sync_act;
  assign blank    = count_q[W-1];
  assign wrap     = step && (count_q == CNT_MAX);
  assign count    = count_q;

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: pixel divider, horizontal/vertical timing, shader-start
// pulses and program-memory arbitration that grants the loader in vblank only.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_RES    = DEF_V_RES,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int POLARITY = 0,
  parameter int PIX_DIV  = 4,
  localparam int XW      = cnt_width(H_RES + H_FP + H_SYNC + H_BP),
  localparam int YW      = cnt_width(V_RES + V_FP + V_SYNC + V_BP)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load_req,
  input  logic                 load_done,
  output logic                 load_grant,
  output logic                 frame_skip,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank,
  output logic signed [XW-1:0] x,
  output logic signed [YW-1:0] y,
  output logic                 pix_stb,
  output logic                 shader_start,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int              DW       = $clog2(PIX_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic signed [YW-1:0] Y_MIN        = YW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [YW-1:0] Y_GRANT_MAX  = YW'(-2);
  localparam logic signed [YW-1:0] Y_LAST_BLANK = YW'(-1);

  logic [DW-1:0] div_q, div_d;
  logic          h_blank, v_blank;
  arb_state_t    state_q, state_d;
  logic          skip_q, skip_d;
  logic          grant_window;

  // Pixel divider
  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = pix_stb ? '0 : div_q + DW'(1);
    end
  end

  assign pix_stb = enable && (div_q == DIV_LAST);

  sync_counter #(
    .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POLARITY(POLARITY), .W(XW)
  ) u_h_counter (
    .clk  (clk),
    .reset(reset),
    .step (pix_stb),
    .wrap (line_start),
    .sync (hsync),
    .blank(h_blank),
    .count(x)
  );

  sync_counter #(
    .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POLARITY(POLARITY), .W(YW)
  ) u_v_counter (
    .clk  (clk),
    .reset(reset),
    .step (line_start),
    .wrap (frame_start),
    .sync (vsync),
    .blank(v_blank),
    .count(y)
  );

  assign blank        = h_blank || v_blank;
  assign shader_start = enable && (div_q == '0) && !blank && !skip_q;

  // Granting no later than y == -2 leaves the loader at least one whole blank line.
  assign grant_window = (y >= Y_MIN) && (y <= Y_GRANT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_req && grant_window) state_d = GRANTED;
      GRANTED: if (load_done)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_grant = (state_q == GRANTED);
  end

  // A loader still holding memory when active video begins costs the whole frame.
  always_comb begin
    skip_d = skip_q;
    if (frame_start) begin
      skip_d = 1'b0;
    end else if (line_start && (y == Y_LAST_BLANK) && (state_q == GRANTED) && !load_done) begin
      skip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      skip_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      skip_q <= skip_d;
    end
  end

  assign frame_skip = skip_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a shrunken 15x13 timing with PIX_DIV=2,
// plus a default-parameter instance for reset values and default geometry.
module tb_frame_scheduler;

  // Small geometry: x in -7..7, y in -7..5, 30 clk per line, 390 clk per frame.
  localparam int FRAME = 390;

  logic clk;
  logic reset, enable, load_req, load_done;

  logic              load_grant, frame_skip, hsync, vsync, blank;
  logic              pix_stb, shader_start, line_start, frame_start;
  logic signed [4:0] x, y;

  logic               d_load_grant, d_frame_skip, d_hsync, d_vsync, d_blank;
  logic               d_pix_stb, d_shader_start, d_line_start, d_frame_start;
  logic signed [10:0] d_x, d_y;

  int checks = 0;
  int errors = 0;

  int m_div, m_x, m_y;
  bit m_grant, m_skip;
  int n_pix, n_line, n_frame, n_sh, n_grant, n_skip, fs_idx, cyc_i;

  frame_scheduler #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .POLARITY(0), .PIX_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .load_req(load_req), .load_done(load_done),
    .load_grant(load_grant), .frame_skip(frame_skip),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .x(x), .y(y), .pix_stb(pix_stb), .shader_start(shader_start),
    .line_start(line_start), .frame_start(frame_start)
  );

  frame_scheduler dut_def (
    .clk(clk), .reset(reset), .enable(enable),
    .load_req(1'b0), .load_done(1'b0),
    .load_grant(d_load_grant), .frame_skip(d_frame_skip),
    .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank),
    .x(d_x), .y(d_y), .pix_stb(d_pix_stb), .shader_start(d_shader_start),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_x = -7; m_y = -7; m_grant = 0; m_skip = 0;
  endtask

  // Compare every output against the reference, then clock once and advance it.
  task automatic cycle();
    bit e_pix, e_line, e_frame, e_blank, e_hs, e_vs, e_sh, n_gr;
    #1;
    e_pix   = enable && (m_div == 1);
    e_line  = e_pix && (m_x == 7);
    e_frame = e_line && (m_y == 5);
    e_blank = (m_x < 0) || (m_y < 0);
    e_hs    = !((m_x >= -5) && (m_x <= -3));
    e_vs    = !((m_y >= -5) && (m_y <= -4));
    e_sh    = enable && (m_div == 0) && !e_blank && !m_skip;
    check("x", x, m_x);
    check("y", y, m_y);
    check("hsync", hsync, e_hs);
    check("vsync", vsync, e_vs);
    check("blank", blank, e_blank);
    check("pix_stb", pix_stb, e_pix);
    check("line_start", line_start, e_line);
    check("frame_start", frame_start, e_frame);
    check("shader_start", shader_start, e_sh);
    check("load_grant", load_grant, m_grant);
    check("frame_skip", frame_skip, m_skip);
    n_pix   += int'(pix_stb);
    n_line  += int'(line_start);
    n_frame += int'(frame_start);
    n_sh    += int'(shader_start);
    n_grant += int'(load_grant);
    n_skip  += int'(frame_skip);
    if (frame_start) fs_idx = cyc_i;
    @(posedge clk);
    n_gr = m_grant;
    if (!m_grant && load_req && (m_y <= -2)) n_gr = 1;
    else if (m_grant && load_done)           n_gr = 0;
    if (e_frame) m_skip = 0;
    else if (e_line && (m_y == -1) && m_grant && !load_done) m_skip = 1;
    if (e_pix) begin
      m_div = 0;
      if (m_x == 7) begin
        m_x = -7;
        m_y = (m_y == 5) ? -7 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
    end else if (enable) begin
      m_div = m_div + 1;
    end
    m_grant = n_gr;
    #1;
  endtask

  task automatic run_frame(input int n, input int req_from, input int req_to,
                           input int done_at, input int off_from, input int off_len);
    n_pix = 0; n_line = 0; n_frame = 0; n_sh = 0; n_grant = 0; n_skip = 0; fs_idx = -1;
    for (int i = 0; i < n; i++) begin
      load_req  = (i >= req_from) && (i < req_to);
      load_done = (i == done_at);
      enable    = !((i >= off_from) && (i < off_from + off_len));
      cyc_i     = i;
      cycle();
    end
    load_req = 0; load_done = 0; enable = 1;
  endtask

  initial begin
    reset = 1; enable = 0; load_req = 0; load_done = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset values, small and default geometry
    check("rst_x", x, -7);
    check("rst_y", y, -7);
    check("rst_blank", blank, 1);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_pix_stb", pix_stb, 0);
    check("rst_grant", load_grant, 0);
    check("rst_skip", frame_skip, 0);
    check("def_rst_x", d_x, -160);
    check("def_rst_y", d_y, -45);
    check("def_rst_hsync", d_hsync, 1);
    check("def_rst_vsync", d_vsync, 1);
    check("def_rst_blank", d_blank, 1);
    check("def_rst_grant", d_load_grant, 0);
    reset = 0;
    model_reset();

    // One plain frame
    run_frame(FRAME, -1, -1, -1, -1, 0);
    check("f1_frames", n_frame, 1);
    check("f1_lines", n_line, 13);
    check("f1_pix", n_pix, 195);
    check("f1_shader", n_sh, 48);
    check("f1_fs_idx", fs_idx, 389);
    check("f1_x_end", x, -7);
    check("f1_y_end", y, -7);
    check("def_x_390", d_x, -63);
    check("def_y_390", d_y, -45);

    // Enable dropped for 37 cycles inside active line 0
    run_frame(FRAME + 37, -1, -1, -1, 225, 37);
    check("gate_frames", n_frame, 1);
    check("gate_fs_idx", fs_idx, 426);
    check("gate_pix", n_pix, 195);
    check("gate_shader", n_sh, 48);

    // Loader in time: request at y=-6, release at y=-3
    run_frame(FRAME, 30, 31, 120, -1, 0);
    check("intime_grant_cyc", n_grant, 90);
    check("intime_skip_cyc", n_skip, 0);
    check("intime_shader", n_sh, 48);

    // Request from y=-1 through the active frame: no grant this frame
    run_frame(FRAME, 180, FRAME, -1, -1, 0);
    check("late_req_grant_cyc", n_grant, 0);
    check("late_req_shader", n_sh, 48);

    // Grant at y=-7 of the next frame, held past the boundary
    run_frame(FRAME, 0, 1, 250, -1, 0);
    check("skip_grant_cyc", n_grant, 250);
    check("skip_cyc", n_skip, 180);
    check("skip_shader", n_sh, 0);
    check("skip_cleared", frame_skip, 0);

    // Release on the exact boundary cycle: no skip
    run_frame(FRAME, 0, 1, 209, -1, 0);
    check("edge_grant_cyc", n_grant, 209);
    check("edge_skip_cyc", n_skip, 0);
    check("edge_shader", n_sh, 48);

    // Reset mid-frame while granted
    run_frame(40, 0, 1, -1, -1, 0);
    check("pre_rst_grant", load_grant, 1);
    reset = 1;
    @(posedge clk); #1;
    check("mid_rst_grant", load_grant, 0);
    check("mid_rst_x", x, -7);
    check("mid_rst_y", y, -7);
    check("mid_rst_blank", blank, 1);
    reset = 0;
    model_reset();
    run_frame(60, -1, -1, -1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
